// File: rtl/ttt_pkg.sv
// Shared encodings, winning-line table and FSM states for the tic-tac-toe judge.
package ttt_pkg;

  // Game-status encodings reported on result.
  localparam logic [1:0] RES_P1   = 2'b11;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b01;
  localparam logic [1:0] RES_NONE = 2'b00;

  // Cell encodings as stored by the board memory (after its bit flip).
  // Field value 2'b10 never gets written and is treated as empty.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b11;
  localparam logic [1:0] CELL_P2    = 2'b01;
  localparam logic [1:0] CELL_UNUSED = 2'b10;

  localparam int NUM_LINES = 8;

  // Winning lines in scan order: rows, columns, diagonals.
  localparam logic [3:0] LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Extract cell i (bits [2i+1:2i]) from an 18-bit board word.
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] i);
    return board[{i, 1'b0} +: 2];
  endfunction

  // A cell counts as occupied only when it holds a real player code.
  function automatic logic cell_filled(input logic [17:0] board, input logic [3:0] i);
    logic [1:0] c;
    c = cell_at(board, i);
    return (c != CELL_EMPTY) && (c != CELL_UNUSED);
  endfunction

endpackage

// File: rtl/flops.sv
// Two-phase flop primitives: a ph2-sampled master stage feeding a ph1 slave
// stage. Data presented before ph2 appears on q at the following ph1.

module flopr #(
  parameter int W = 1
) (
  input  logic         ph1,
  input  logic         ph2,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] m;

  // Master stage: capture next value, synchronous reset to zero.
  always_ff @(posedge ph2) m <= reset ? '0 : d;

  // Slave stage: publish the captured value.
  always_ff @(posedge ph1) q <= m;

endmodule

module flopenr #(
  parameter int W = 1
) (
  input  logic         ph1,
  input  logic         ph2,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] m;

  // Master stage: load on enable, otherwise hold the published value.
  always_ff @(posedge ph2) m <= reset ? '0 : (en ? d : q);

  // Slave stage: publish the captured value.
  always_ff @(posedge ph1) q <= m;

endmodule

// File: rtl/game_judge_line_check.sv
// Combinational test of one three-cell line for a complete player line.
module line_check
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       p1Line,
  output logic       p2Line
);

  // A line belongs to a player only when all three cells carry that code.
  always_comb begin
    p1Line = (a == CELL_P1) && (b == CELL_P1) && (c == CELL_P1);
    p2Line = (a == CELL_P2) && (b == CELL_P2) && (c == CELL_P2);
  end

endmodule

// File: rtl/game_judge.sv
// Sequential win/tie judge: snapshots the board on start, scans the eight
// winning lines one per cycle, then reports the outcome and keeps scores.
//
// Handshake: start is a single-cycle request accepted only in IDLE or DONE;
// busy is high for the eight scan cycles; done pulses for one cycle exactly
// when result and the score counters carry the new values. There is no
// backpressure; a start seen while busy is dropped.
module game_judge
  import ttt_pkg::*;
#(
  parameter int SCORE_W = 4
) (
  input  logic               ph1,
  input  logic               ph2,
  input  logic               reset,
  input  logic               start,
  input  logic [17:0]        gameBoard,
  input  logic               clrScore,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic               gameOver,
  output logic [SCORE_W-1:0] p1Wins,
  output logic [SCORE_W-1:0] p2Wins,
  output logic [SCORE_W-1:0] ties,
  output logic [1:0]         dbgState
);

  // FSM state
  logic [1:0] state_q;
  logic [1:0] state_d;
  state_t     state;
  state_t     state_n;

  // Scan datapath
  logic [17:0] snap_q;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic        p1Hit_q, p1Hit_d;
  logic        p2Hit_q, p2Hit_d;
  logic [1:0]  firstWinner_q, firstWinner_d;
  logic [1:0]  cellA, cellB, cellC;
  logic        curP1, curP2;
  logic        load;
  logic        lastScan;
  logic        anyPrev;
  logic        boardFull;
  logic [1:0]  nextFirst;
  logic [1:0]  finalRes;

  // Score counters
  logic [SCORE_W-1:0] p1Wins_d, p2Wins_d, ties_d;

  assign state    = state_t'(state_q);
  assign state_d  = state_n;
  assign dbgState = state_q;

  // A new request is honoured only when no scan is running.
  assign load     = start && ((state == S_IDLE) || (state == S_DONE));
  assign lastScan = (state == S_SCAN) && (idx_q == 3'd7);

  flopr #(.W(2)) state_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(state_d), .q(state_q)
  );

  // Next-state logic; the scan always runs all eight lines.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_SCAN;
      S_SCAN:  if (idx_q == 3'd7) state_n = S_DONE;
      S_DONE:  state_n = start ? S_SCAN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // The snapshot isolates the scan from board writes made while busy.
  flopenr #(.W(18)) snap_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(load), .d(gameBoard), .q(snap_q)
  );

  // Fetch the three cells of the line currently being scanned.
  always_comb begin
    cellA = cell_at(snap_q, LINES[idx_q][0]);
    cellB = cell_at(snap_q, LINES[idx_q][1]);
    cellC = cell_at(snap_q, LINES[idx_q][2]);
  end

  line_check u_line_check (
    .a(cellA), .b(cellB), .c(cellC), .p1Line(curP1), .p2Line(curP2)
  );

  // Tie detection: every snapshot cell holds a player code.
  always_comb begin
    boardFull = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (!cell_filled(snap_q, 4'(i))) boardFull = 1'b0;
    end
  end

  // Winner tracking: the earliest line hit in scan order decides the game.
  // The final outcome is formed during the last scan cycle so that result
  // and the counters are already updated while done is high.
  always_comb begin
    anyPrev   = p1Hit_q || p2Hit_q;
    nextFirst = firstWinner_q;
    if (!anyPrev && (curP1 || curP2)) nextFirst = curP1 ? RES_P1 : RES_P2;
    if (anyPrev || curP1 || curP2) finalRes = nextFirst;
    else if (boardFull)            finalRes = RES_TIE;
    else                           finalRes = RES_NONE;
  end

  // Scan bookkeeping: clear on a new request, advance while scanning.
  always_comb begin
    idx_d         = idx_q;
    p1Hit_d       = p1Hit_q;
    p2Hit_d       = p2Hit_q;
    firstWinner_d = firstWinner_q;
    if (load) begin
      idx_d         = 3'd0;
      p1Hit_d       = 1'b0;
      p2Hit_d       = 1'b0;
      firstWinner_d = RES_NONE;
    end else if (state == S_SCAN) begin
      idx_d         = idx_q + 3'd1;
      p1Hit_d       = p1Hit_q || curP1;
      p2Hit_d       = p2Hit_q || curP2;
      firstWinner_d = nextFirst;
    end
  end

  flopr #(.W(3)) idx_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(idx_d), .q(idx_q)
  );
  flopr #(.W(1)) p1hit_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(p1Hit_d), .q(p1Hit_q)
  );
  flopr #(.W(1)) p2hit_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(p2Hit_d), .q(p2Hit_q)
  );
  flopr #(.W(2)) first_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(firstWinner_d), .q(firstWinner_q)
  );

  // Result holds from one completed scan to the next.
  flopenr #(.W(2)) result_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(lastScan), .d(finalRes), .q(result)
  );

  // Saturating score update; a clear overrides any same-cycle increment.
  always_comb begin
    p1Wins_d = p1Wins;
    p2Wins_d = p2Wins;
    ties_d   = ties;
    if (lastScan) begin
      if ((finalRes == RES_P1) && (p1Wins != '1)) p1Wins_d = p1Wins + 1'b1;
      if ((finalRes == RES_P2) && (p2Wins != '1)) p2Wins_d = p2Wins + 1'b1;
      if ((finalRes == RES_TIE) && (ties != '1))  ties_d   = ties + 1'b1;
    end
    if (clrScore) begin
      p1Wins_d = '0;
      p2Wins_d = '0;
      ties_d   = '0;
    end
  end

  flopr #(.W(SCORE_W)) p1_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(p1Wins_d), .q(p1Wins)
  );
  flopr #(.W(SCORE_W)) p2_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(p2Wins_d), .q(p2Wins)
  );
  flopr #(.W(SCORE_W)) tie_reg (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(ties_d), .q(ties)
  );

  assign busy     = (state == S_SCAN);
  assign done     = (state == S_DONE);
  assign gameOver = (result != RES_NONE);

endmodule
